// File: rtl/digit_check_pkg.sv
// Shared types and elaboration helpers for the digit-serial add/check block.
package digit_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Digit index width; a single-digit configuration still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
    int unsigned n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_legal(input int unsigned width, input int unsigned digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_add_slice.sv
// One digit of the adder: DIGIT-bit add with carry plus an inequality flag against the expected digit.
module digit_add_slice #(
  parameter int unsigned DIGIT = 16
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  input  logic [DIGIT-1:0] expd,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             ne
);

  logic [DIGIT:0] w_s;

  assign w_s = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
  assign sum = w_s[DIGIT-1:0];
  assign co  = w_s[DIGIT];
  assign ne  = |(w_s[DIGIT-1:0] ^ expd);

endmodule

// File: rtl/digit_serial_add_check.sv
// Digit-serial checker of in_data + ADDEND + cin == EXPECT, LSB digit first, carry held in a register.
// Optional macro DIGIT_CHECK_EARLY_EXIT_EN: finish on the first mismatching digit instead of constant time.
module digit_serial_add_check
  import digit_check_pkg::*;
#(
  parameter int unsigned      WIDTH  = 256,
  parameter int unsigned      DIGIT  = 16,
  parameter logic [WIDTH-1:0] ADDEND = '0,
  parameter logic [WIDTH-1:0] EXPECT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic             cout
);

  localparam int unsigned N         = num_digits(WIDTH, DIGIT);
  localparam int unsigned CW        = cnt_width(WIDTH, DIGIT);
  localparam bit          PARAMS_OK = params_legal(WIDTH, DIGIT);

  if (!PARAMS_OK) begin : g_bad_params
    $error("digit_serial_add_check: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_op;
  logic             r_carry;
  logic             r_diff;
  logic [CW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_match;
  logic             r_cout;

  logic [DIGIT-1:0] w_op_dig;
  logic [DIGIT-1:0] w_add_dig;
  logic [DIGIT-1:0] w_exp_dig;
  logic [DIGIT-1:0] w_unused_sum;
  logic             w_co;
  logic             w_ne;
  logic             w_last;
  logic             w_stop;

  // Select digit k of the operand and of both constants.
  always_comb begin
    w_op_dig  = '0;
    w_add_dig = '0;
    w_exp_dig = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (r_idx == CW'(k)) begin
        w_op_dig  = r_op[k*DIGIT +: DIGIT];
        w_add_dig = ADDEND[k*DIGIT +: DIGIT];
        w_exp_dig = EXPECT[k*DIGIT +: DIGIT];
      end
    end
  end

  digit_add_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a    (w_op_dig),
    .b    (w_add_dig),
    .ci   (r_carry),
    .expd (w_exp_dig),
    .sum  (w_unused_sum),
    .co   (w_co),
    .ne   (w_ne)
  );

  assign w_last = (r_idx == CW'(N - 1));

`ifdef DIGIT_CHECK_EARLY_EXIT_EN
  assign w_stop = w_last | w_ne;
`else
  assign w_stop = w_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_carry <= 1'b0;
      r_diff  <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_op    <= in_data;
            r_carry <= cin;
            r_diff  <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_carry <= w_co;
          r_diff  <= r_diff | w_ne;
          r_idx   <= r_idx + CW'(1);
          if (w_stop) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_match <= ~(r_diff | w_ne);
            r_cout  <= w_co;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign match = r_match;
  assign cout  = r_cout;

endmodule
